disp_framebuf: RTL and testbench

//  Parametrised frame buffer between the pixel producer (menu/graphics engine) and the VGA scan-out.

---
 rtl/disp_framebuf.sv | 165 ++++++++++++++++
 tb/tb_disp_framebuf.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_framebuf.sv
// Frame buffer between the pixel producer and the VGA scan-out.
// One writer port, one fixed-latency (2-cycle) reader port, optional double
// buffering with a page swap at frame start, and a hardware clear engine.
//
// Handshake: a write is accepted in any cycle where o_wr_ready=1 and i_wr_en=1;
// there is no backpressure queue, so a write offered while o_wr_ready=0 is lost.
// Reads are always accepted; o_rd_valid marks o_rd_data two cycles after i_rd_en.
module disp_framebuf #(
  parameter int              DATA_W     = 12,
  parameter int              ADDR_W     = 17,
  parameter int              DEPTH      = 76800,
  parameter int              DOUBLE_BUF = 1,
  parameter logic [DATA_W-1:0] CLR_COLOR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_clr_req,
  output logic              o_clr_done,
  input  logic              i_swap_req,
  input  logic              i_frame_start,
  output logic              o_swap_done,
  output logic              o_busy,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_disp_bank,
  output logic [1:0]        o_dbg_state
);

  localparam int MEM_WORDS = (DOUBLE_BUF + 1) * DEPTH;
  localparam int MEM_AW    = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CLEAR     = 2'd1,
    S_SWAP_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_disp_bank;
  logic                r_wr_bank;
  logic                r_clr_done;
  logic                r_swap_done;
  logic                w_clr_wr;
  logic                w_clr_last;
  logic                w_swap_fire;

  logic [DATA_W-1:0]   r_mem [MEM_WORDS];
  logic [DATA_W-1:0]   r_rd_q;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_v1;
  logic                r_rd_v2;
  logic                r_rd_oor;

  logic                w_wr_in_range;
  logic                w_rd_in_range;
  logic                w_user_wr;
  logic [MEM_AW-1:0]   w_wr_idx;
  logic [MEM_AW-1:0]   w_clr_idx;
  logic [MEM_AW-1:0]   w_rd_idx;

  assign w_wr_in_range = ({1'b0, i_wr_addr} < DEPTH_C);
  assign w_rd_in_range = ({1'b0, i_rd_addr} < DEPTH_C);
  assign w_user_wr     = (r_state == S_IDLE) && i_wr_en && w_wr_in_range;
  // Bank base offsets; out-of-range addresses are steered to word 0 and gated off.
  assign w_wr_idx  = MEM_AW'(r_wr_bank ? DEPTH : 0)
                   + (w_wr_in_range ? MEM_AW'(i_wr_addr) : '0);
  assign w_clr_idx = MEM_AW'(r_wr_bank ? DEPTH : 0) + MEM_AW'(r_clr_cnt);
  assign w_rd_idx  = MEM_AW'(r_disp_bank ? DEPTH : 0)
                   + (w_rd_in_range ? MEM_AW'(i_rd_addr) : '0);

  // Next-state logic: clear beats swap when both arrive in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_wr    = 1'b0;
    w_clr_last  = 1'b0;
    w_swap_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clr_req)       w_state_nxt = S_CLEAR;
        else if (i_swap_req) w_state_nxt = S_SWAP_WAIT;
      end
      S_CLEAR: begin
        w_clr_wr = 1'b1;
        if (r_clr_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_clr_last  = 1'b1;
        end
      end
      S_SWAP_WAIT: begin
        if (i_frame_start) begin
          w_state_nxt = S_IDLE;
          w_swap_fire = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, clear counter, bank pointers and completion pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_clr_cnt   <= '0;
      r_disp_bank <= 1'b0;
      r_wr_bank   <= (DOUBLE_BUF != 0);
      r_clr_done  <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_done  <= w_clr_last;
      r_swap_done <= w_swap_fire;
      if (r_state == S_IDLE && i_clr_req) r_clr_cnt <= '0;
      else if (w_clr_wr)                  r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_swap_fire && DOUBLE_BUF != 0) begin
        r_disp_bank <= ~r_disp_bank;
        r_wr_bank   <= ~r_wr_bank;
      end
    end
  end

  // Dual-port RAM: read-first on collisions; writes suppressed during reset
  // so an aborted clear leaves the word it was on untouched.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_clr_wr)       r_mem[w_clr_idx] <= CLR_COLOR;
      else if (w_user_wr) r_mem[w_wr_idx]  <= i_wr_data;
    end
    r_rd_q <= r_mem[w_rd_idx];
  end

  // Read pipeline: bank and range are captured in the rd_en cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_v1   <= 1'b0;
      r_rd_v2   <= 1'b0;
      r_rd_oor  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_v1  <= i_rd_en;
      r_rd_oor <= ~w_rd_in_range;
      r_rd_v2  <= r_rd_v1;
      if (r_rd_v1) r_rd_data <= r_rd_oor ? '0 : r_rd_q;
    end
  end

  assign o_wr_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_clr_done  = r_clr_done;
  assign o_swap_done = r_swap_done;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_v2;
  assign o_disp_bank = r_disp_bank;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_disp_framebuf.sv
// Directed testbench for disp_framebuf: a double-buffered instance (u_dut)
// and a single-bank instance (u_dut0) sharing one clock.
module tb_disp_framebuf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Double-buffered instance signals
  logic        rst = 1'b1, wr_en = 1'b0, clr_req = 1'b0, swap_req = 1'b0;
  logic        frame_start = 1'b0, rd_en = 1'b0;
  logic [4:0]  wr_addr = '0, rd_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready, clr_done, swap_done, busy, rd_valid, disp_bank;
  logic [11:0] rd_data;
  logic [1:0]  dbg_state;

  // Single-bank instance signals
  logic        s_rst = 1'b1, s_wr_en = 1'b0, s_clr_req = 1'b0, s_swap_req = 1'b0;
  logic        s_frame_start = 1'b0, s_rd_en = 1'b0;
  logic [4:0]  s_wr_addr = '0, s_rd_addr = '0;
  logic [11:0] s_wr_data = '0;
  logic        s_wr_ready, s_clr_done, s_swap_done, s_busy, s_rd_valid, s_disp_bank;
  logic [11:0] s_rd_data;
  logic [1:0]  s_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  disp_framebuf #(.DATA_W(12), .ADDR_W(5), .DEPTH(16), .DOUBLE_BUF(1), .CLR_COLOR(12'h0F0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ready(wr_ready), .i_clr_req(clr_req), .o_clr_done(clr_done),
    .i_swap_req(swap_req), .i_frame_start(frame_start), .o_swap_done(swap_done),
    .o_busy(busy), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .o_disp_bank(disp_bank), .o_dbg_state(dbg_state));

  disp_framebuf #(.DATA_W(12), .ADDR_W(5), .DEPTH(16), .DOUBLE_BUF(0), .CLR_COLOR(12'h0F0)) u_dut0 (
    .i_clk(clk), .i_rst(s_rst), .i_wr_en(s_wr_en), .i_wr_addr(s_wr_addr), .i_wr_data(s_wr_data),
    .o_wr_ready(s_wr_ready), .i_clr_req(s_clr_req), .o_clr_done(s_clr_done),
    .i_swap_req(s_swap_req), .i_frame_start(s_frame_start), .o_swap_done(s_swap_done),
    .o_busy(s_busy), .i_rd_en(s_rd_en), .i_rd_addr(s_rd_addr), .o_rd_data(s_rd_data),
    .o_rd_valid(s_rd_valid), .o_disp_bank(s_disp_bank), .o_dbg_state(s_dbg_state));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Issue one read; on return the result is on rd_data/rd_valid.
  task automatic rd1(input logic [4:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic swap1();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic s_wr1(input logic [4:0] a, input logic [11:0] d);
    s_wr_en = 1'b1; s_wr_addr = a; s_wr_data = d;
    tick();
    s_wr_en = 1'b0;
  endtask

  task automatic s_rd1(input logic [4:0] a);
    s_rd_en = 1'b1; s_rd_addr = a;
    tick();
    s_rd_en = 1'b0;
    tick();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (wr_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_wr_ready: got %b exp 1", wr_ready); end
    n_cmp++; if (rd_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_rd_valid: got %b exp 0", rd_valid); end
    n_cmp++; if (rd_data !== 12'h000) begin n_bad++; $display("FAIL rst_rd_data: got %h exp 000", rd_data); end
    n_cmp++; if (disp_bank !== 1'b0) begin n_bad++; $display("FAIL rst_disp_bank: got %b exp 0", disp_bank); end
    n_cmp++; if (clr_done !== 1'b0 || swap_done !== 1'b0)
      begin n_bad++; $display("FAIL rst_done: got clr=%b swap=%b exp 0/0", clr_done, swap_done); end
    n_cmp++; if (s_busy !== 1'b0 || s_disp_bank !== 1'b0)
      begin n_bad++; $display("FAIL rst_sb: got busy=%b bank=%b exp 0/0", s_busy, s_disp_bank); end
    rst = 1'b0; s_rst = 1'b0;
    tick();
  endtask

  task automatic test_write_swap();
    wr1(5'd3, 12'hABC);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sw_wait_busy: got %b exp 1", busy); end
    tick();
    n_cmp++; if (swap_done !== 1'b0 || disp_bank !== 1'b0)
      begin n_bad++; $display("FAIL sw_early: got done=%b bank=%b exp 0/0", swap_done, disp_bank); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_cmp++; if (swap_done !== 1'b1 || disp_bank !== 1'b1)
      begin n_bad++; $display("FAIL sw_fire: got done=%b bank=%b exp 1/1", swap_done, disp_bank); end
    tick();
    n_cmp++; if (swap_done !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL sw_pulse: got done=%b busy=%b exp 0/0", swap_done, busy); end
    rd_en = 1'b1; rd_addr = 5'd3;
    tick();
    rd_en = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_lat1: got %b exp 0", rd_valid); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 12'hABC)
      begin n_bad++; $display("FAIL rd_lat2: got v=%b d=%h exp 1/abc", rd_valid, rd_data); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_lat3: got %b exp 0", rd_valid); end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int done_cnt;
    int done_idx;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_idx = i; end
      if (i == 3) begin
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL clr_wr_ready: got %b exp 0", wr_ready); end
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 12'h123;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    n_cmp++; if (busy_cnt != 16) begin n_bad++; $display("FAIL clr_busy_len: got %0d exp 16", busy_cnt); end
    n_cmp++; if (done_cnt != 1 || done_idx != 16)
      begin n_bad++; $display("FAIL clr_done_pulse: got cnt=%0d at=%0d exp 1 at 16", done_cnt, done_idx); end
    swap1();
    for (int i = 0; i < 16; i++) begin
      rd1(5'(i));
      n_cmp++; if (rd_data !== 12'h0F0)
        begin n_bad++; $display("FAIL clr_word%0d: got %h exp 0f0", i, rd_data); end
    end
  endtask

  task automatic test_swap_same_cycle();
    wr1(5'd2, 12'h222);
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || swap_done !== 1'b0)
      begin n_bad++; $display("FAIL same_accept: got busy=%b done=%b exp 1/0", busy, swap_done); end
    tick();
    n_cmp++; if (disp_bank !== 1'b0 || swap_done !== 1'b0)
      begin n_bad++; $display("FAIL same_noswap: got bank=%b done=%b exp 0/0", disp_bank, swap_done); end
    rd_en = 1'b1; rd_addr = 5'd2; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_cmp++; if (swap_done !== 1'b1 || disp_bank !== 1'b1)
      begin n_bad++; $display("FAIL same_swap: got done=%b bank=%b exp 1/1", swap_done, disp_bank); end
    tick();
    rd_en = 1'b0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 12'h0F0)
      begin n_bad++; $display("FAIL inflight_old: got v=%b d=%h exp 1/0f0", rd_valid, rd_data); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 12'h222)
      begin n_bad++; $display("FAIL inflight_new: got v=%b d=%h exp 1/222", rd_valid, rd_data); end
  endtask

  task automatic test_clr_swap_same();
    int busy_cnt;
    int clr_cnt;
    int sw_cnt;
    busy_cnt = 0; clr_cnt = 0; sw_cnt = 0;
    clr_req = 1'b1; swap_req = 1'b1;
    tick();
    clr_req = 1'b0; swap_req = 1'b0; frame_start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (busy) busy_cnt++;
      if (clr_done) clr_cnt++;
      if (swap_done) sw_cnt++;
      tick();
    end
    frame_start = 1'b0;
    n_cmp++; if (busy_cnt != 16 || clr_cnt != 1)
      begin n_bad++; $display("FAIL cs_clear: got busy=%0d done=%0d exp 16/1", busy_cnt, clr_cnt); end
    n_cmp++; if (sw_cnt != 0 || disp_bank !== 1'b1)
      begin n_bad++; $display("FAIL cs_noswap: got swaps=%0d bank=%b exp 0/1", sw_cnt, disp_bank); end
    swap1();
    wr1(5'd4, 12'h444);
    wr1(5'd17, 12'hFFF);
    rd1(5'd1);
    n_cmp++; if (rd_data !== 12'h0F0) begin n_bad++; $display("FAIL wr_oor: got %h exp 0f0", rd_data); end
    rd1(5'd20);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 12'h000)
      begin n_bad++; $display("FAIL rd_oor: got v=%b d=%h exp 1/000", rd_valid, rd_data); end
  endtask

  task automatic test_rst_mid_clear();
    logic [11:0] exp_v;
    for (int i = 0; i < 16; i++) wr1(5'(i), 12'h500 + 12'(i));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (6) tick();
    rd_en = 1'b1; rd_addr = 5'd0;
    tick();
    rd_en = 1'b0; rst = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || clr_done !== 1'b0 || disp_bank !== 1'b0)
      begin n_bad++; $display("FAIL mid_rst: got busy=%b done=%b bank=%b exp 0/0/0", busy, clr_done, disp_bank); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL flush1: got %b exp 0", rd_valid); end
    rst = 1'b0;
    tick();
    n_cmp++; if (rd_valid !== 1'b0 || clr_done !== 1'b0)
      begin n_bad++; $display("FAIL flush2: got v=%b done=%b exp 0/0", rd_valid, clr_done); end
    swap1();
    for (int i = 0; i < 16; i++) begin
      exp_v = (i < 7) ? 12'h0F0 : (12'h500 + 12'(i));
      rd1(5'(i));
      n_cmp++; if (rd_data !== exp_v)
        begin n_bad++; $display("FAIL part_clr%0d: got %h exp %h", i, rd_data, exp_v); end
    end
  endtask

  task automatic test_single_buf();
    s_wr1(5'd5, 12'h777);
    s_swap_req = 1'b1;
    tick();
    s_swap_req = 1'b0; s_frame_start = 1'b1;
    tick();
    s_frame_start = 1'b0;
    n_cmp++; if (s_swap_done !== 1'b1 || s_disp_bank !== 1'b0)
      begin n_bad++; $display("FAIL sb_swap: got done=%b bank=%b exp 1/0", s_swap_done, s_disp_bank); end
    s_rd1(5'd5);
    n_cmp++; if (s_rd_valid !== 1'b1 || s_rd_data !== 12'h777)
      begin n_bad++; $display("FAIL sb_read: got v=%b d=%h exp 1/777", s_rd_valid, s_rd_data); end
    s_wr_en = 1'b1; s_wr_addr = 5'd5; s_wr_data = 12'h999;
    s_rd_en = 1'b1; s_rd_addr = 5'd5;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    tick();
    n_cmp++; if (s_rd_data !== 12'h777) begin n_bad++; $display("FAIL rd_first: got %h exp 777", s_rd_data); end
    s_rd1(5'd5);
    n_cmp++; if (s_rd_data !== 12'h999) begin n_bad++; $display("FAIL sb_after: got %h exp 999", s_rd_data); end
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_clear();
    test_swap_same_cycle();
    test_clr_swap_same();
    test_rst_mid_clear();
    test_single_buf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
